// File: rtl/trans_framer_pkg.sv
// -----------------------------------------------------------------------------
// trans_framer_pkg
// Shared types and constants for the transaction framer.
//   trans_framer_state_e : framer state encoding (eight states)
//   FRAME_LEN            : number of strobe cycles in one frame
//   DEFAULT_CNT_W        : default width of the completed-frame counter
//   strobe_decode()      : one-hot strobe vector {trans,start_trans,a,b,c,end_trans}
// -----------------------------------------------------------------------------
package trans_framer_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        S_TRANS = 3'd1,
        S_START = 3'd2,
        S_A     = 3'd3,
        S_B     = 3'd4,
        S_C     = 3'd5,
        S_END   = 3'd6,
        GAP     = 3'd7
    } trans_framer_state_e;

    localparam int FRAME_LEN     = 6;
    localparam int DEFAULT_CNT_W = 16;

    // Bit 5 is trans, bit 0 is end_trans; IDLE and GAP decode to all zeros.
    function automatic logic [FRAME_LEN-1:0] strobe_decode(input trans_framer_state_e st);
        case (st)
            S_TRANS: strobe_decode = 6'b100000;
            S_START: strobe_decode = 6'b010000;
            S_A:     strobe_decode = 6'b001000;
            S_B:     strobe_decode = 6'b000100;
            S_C:     strobe_decode = 6'b000010;
            S_END:   strobe_decode = 6'b000001;
            default: strobe_decode = 6'b000000;
        endcase
    endfunction

endpackage

// File: rtl/trans_framer_if.sv
// -----------------------------------------------------------------------------
// trans_framer_if
// Request handshake and frame-strobe bundle of the transaction framer.
//   req_valid / req_ready              : one-bit frame request handshake
//   trans, start_trans, a, b, c,
//   end_trans                          : frame strobes, one per cycle
//   busy                               : framer not idle
//   frame_cnt [CNT_W]                  : completed-frame count
//   abort / frame_aborted              : only when TRANS_FRAMER_ABORT_EN is defined
// Modports: master = requester/observer side, slave = framer side.
// -----------------------------------------------------------------------------
interface trans_framer_if
    import trans_framer_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
) ();

    logic             req_valid;
    logic             req_ready;
    logic             trans;
    logic             start_trans;
    logic             a;
    logic             b;
    logic             c;
    logic             end_trans;
    logic             busy;
    logic [CNT_W-1:0] frame_cnt;
`ifdef TRANS_FRAMER_ABORT_EN
    logic             abort;
    logic             frame_aborted;

    modport master (
        output req_valid, abort,
        input  req_ready, trans, start_trans, a, b, c, end_trans, busy, frame_cnt, frame_aborted
    );

    modport slave (
        input  req_valid, abort,
        output req_ready, trans, start_trans, a, b, c, end_trans, busy, frame_cnt, frame_aborted
    );
`else
    modport master (
        output req_valid,
        input  req_ready, trans, start_trans, a, b, c, end_trans, busy, frame_cnt
    );

    modport slave (
        input  req_valid,
        output req_ready, trans, start_trans, a, b, c, end_trans, busy, frame_cnt
    );
`endif

endinterface

// File: rtl/trans_framer.sv
// -----------------------------------------------------------------------------
// trans_framer
// Generates the six-cycle strobe sequence trans, start_trans, a, b, c,
// end_trans for every accepted one-bit frame request, with an optional idle
// gap of GAP_CYCLES cycles after each frame, and counts completed frames.
//
// Ports:
//   sysclk : clock, all logic on posedge
//   rst_n  : synchronous active-low reset
//   bus    : trans_framer_if.slave (handshake, strobes, busy, frame_cnt)
// Parameters:
//   GAP_CYCLES : idle cycles after end_trans (0 = back-to-back frames)
//   CNT_W      : width of frame_cnt (must match the interface CNT_W)
// Optional feature macro: TRANS_FRAMER_ABORT_EN (abort input, frame_aborted
// output; an abort in S_TRANS..S_C drops the frame without counting it).
// -----------------------------------------------------------------------------
module trans_framer
    import trans_framer_pkg::*;
#(
    parameter int GAP_CYCLES = 0,
    parameter int CNT_W      = DEFAULT_CNT_W
) (
    input  logic          sysclk,
    input  logic          rst_n,
    trans_framer_if.slave bus
);

    // Gap counter holds GAP_CYCLES-1 down to 0.
    localparam int               GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

    trans_framer_state_e  state_r;
    trans_framer_state_e  state_s;
    logic [GAP_W-1:0]     gap_cnt_r;
    logic [GAP_W-1:0]     gap_cnt_s;
    logic [CNT_W-1:0]     frame_cnt_r;
    logic [FRAME_LEN-1:0] strobe_r;
    logic                 busy_r;
    logic                 ready_en_r;
    logic                 ready_s;
    logic                 accept_s;
    logic                 abort_s;
    logic                 abort_hit_s;

`ifdef TRANS_FRAMER_ABORT_EN
    logic                 frame_aborted_r;
    assign abort_s = bus.abort;
`else
    assign abort_s = 1'b0;
`endif

    // Ready decode: ready_en_r keeps req_ready low while reset is applied.
    always_comb begin
        ready_s = 1'b0;
        if (ready_en_r && ((state_r == IDLE) || ((state_r == S_END) && (GAP_CYCLES == 0)))) begin
            ready_s = 1'b1;
        end else begin
            ready_s = 1'b0;
        end
        accept_s = bus.req_valid && ready_s;
    end

    // Next-state and gap-counter logic.
    always_comb begin
        state_s     = state_r;
        gap_cnt_s   = gap_cnt_r;
        abort_hit_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = S_TRANS;
                end else begin
                    state_s = IDLE;
                end
            end
            S_TRANS: state_s = S_START;
            S_START: state_s = S_A;
            S_A:     state_s = S_B;
            S_B:     state_s = S_C;
            S_C:     state_s = S_END;
            S_END: begin
                if (GAP_CYCLES == 0) begin
                    state_s = accept_s ? S_TRANS : IDLE;
                end else begin
                    state_s   = GAP;
                    gap_cnt_s = GAP_LOAD;
                end
            end
            GAP: begin
                if (gap_cnt_r == {GAP_W{1'b0}}) begin
                    state_s = IDLE;
                end else begin
                    gap_cnt_s = gap_cnt_r - GAP_W'(1);
                end
            end
            default: state_s = IDLE;
        endcase

        // Abort overrides the unconditional advance in S_TRANS..S_C only;
        // S_END is excluded so a frame reaching end_trans always counts.
        if (abort_s && (state_r inside {S_TRANS, S_START, S_A, S_B, S_C})) begin
            abort_hit_s = 1'b1;
            if (GAP_CYCLES == 0) begin
                state_s = IDLE;
            end else begin
                state_s   = GAP;
                gap_cnt_s = GAP_LOAD;
            end
        end else begin
            abort_hit_s = 1'b0;
        end
    end

    // State, registered strobes/busy and completed-frame counter.
    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            gap_cnt_r   <= {GAP_W{1'b0}};
            frame_cnt_r <= {CNT_W{1'b0}};
            strobe_r    <= {FRAME_LEN{1'b0}};
            busy_r      <= 1'b0;
            ready_en_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            gap_cnt_r  <= gap_cnt_s;
            // Outputs are decoded from the next state so they line up with state_r.
            strobe_r   <= strobe_decode(state_s);
            busy_r     <= (state_s != IDLE);
            ready_en_r <= 1'b1;
            if (state_r == S_END) begin
                frame_cnt_r <= frame_cnt_r + CNT_W'(1);
            end
        end
    end

`ifdef TRANS_FRAMER_ABORT_EN
    // One-cycle pulse in the cycle after an abort edge.
    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            frame_aborted_r <= 1'b0;
        end else begin
            frame_aborted_r <= abort_hit_s;
        end
    end

    assign bus.frame_aborted = frame_aborted_r;
`endif

    assign bus.req_ready   = ready_s;
    assign bus.trans       = strobe_r[5];
    assign bus.start_trans = strobe_r[4];
    assign bus.a           = strobe_r[3];
    assign bus.b           = strobe_r[2];
    assign bus.c           = strobe_r[1];
    assign bus.end_trans   = strobe_r[0];
    assign bus.busy        = busy_r;
    assign bus.frame_cnt   = frame_cnt_r;

endmodule

// File: tb/tb_trans_framer.sv
// -----------------------------------------------------------------------------
// tb_trans_framer
// Directed bench for trans_framer. Three instances share clock and reset:
//   u0 : GAP_CYCLES=0, CNT_W=16 (reset, single frame, back-to-back, mid-frame
//        reset, abort when TRANS_FRAMER_ABORT_EN is defined)
//   u1 : GAP_CYCLES=2, CNT_W=16 (idle gap)
//   u2 : GAP_CYCLES=0, CNT_W=2  (counter wrap)
// Each step drives inputs on the falling edge and queues the outputs expected
// after the next rising edge; a monitor per instance pops and compares them.
// -----------------------------------------------------------------------------
module tb_trans_framer;
    import trans_framer_pkg::*;

    localparam logic [5:0] SN = 6'b000000;
    localparam logic [5:0] ST = 6'b100000;
    localparam logic [5:0] SS = 6'b010000;
    localparam logic [5:0] SA = 6'b001000;
    localparam logic [5:0] SB = 6'b000100;
    localparam logic [5:0] SC = 6'b000010;
    localparam logic [5:0] SE = 6'b000001;

    typedef struct {
        logic [5:0]  s;
        logic        rdy;
        logic        bsy;
        logic [15:0] cnt;
        logic        fab;
        string       tag;
    } exp_t;

    logic sysclk = 1'b0;
    logic rst_n  = 1'b0;
    int   compared   = 0;
    int   mismatched = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    logic [5:0] seq [6];

    always #5 sysclk = ~sysclk;

    trans_framer_if #(.CNT_W(16)) bus0 ();
    trans_framer_if #(.CNT_W(16)) bus1 ();
    trans_framer_if #(.CNT_W(2))  bus2 ();

    trans_framer #(.GAP_CYCLES(0), .CNT_W(16)) u0 (.sysclk(sysclk), .rst_n(rst_n), .bus(bus0));
    trans_framer #(.GAP_CYCLES(2), .CNT_W(16)) u1 (.sysclk(sysclk), .rst_n(rst_n), .bus(bus1));
    trans_framer #(.GAP_CYCLES(0), .CNT_W(2))  u2 (.sysclk(sysclk), .rst_n(rst_n), .bus(bus2));

    task automatic check(input exp_t e, input logic [5:0] s, input logic rdy,
                         input logic bsy, input logic [15:0] cnt);
        compared++;
        assert (s === e.s) else begin
            mismatched++;
            $error("FAIL %s strobes: observed %b expected %b", e.tag, s, e.s);
        end
        compared++;
        assert (rdy === e.rdy) else begin
            mismatched++;
            $error("FAIL %s req_ready: observed %b expected %b", e.tag, rdy, e.rdy);
        end
        compared++;
        assert (bsy === e.bsy) else begin
            mismatched++;
            $error("FAIL %s busy: observed %b expected %b", e.tag, bsy, e.bsy);
        end
        compared++;
        assert (cnt === e.cnt) else begin
            mismatched++;
            $error("FAIL %s frame_cnt: observed %0d expected %0d", e.tag, cnt, e.cnt);
        end
    endtask

`ifdef TRANS_FRAMER_ABORT_EN
    task automatic check_fab(input exp_t e, input logic fab);
        compared++;
        assert (fab === e.fab) else begin
            mismatched++;
            $error("FAIL %s frame_aborted: observed %b expected %b", e.tag, fab, e.fab);
        end
    endtask
`endif

    // Drive one cycle of stimulus and queue the outputs expected after the next edge.
    task automatic step(input int d, input logic rst, input logic rv, input logic ab,
                        input logic [5:0] s, input logic rdy, input logic bsy,
                        input logic [15:0] cnt, input logic fab, input string tag);
        exp_t e;
        @(negedge sysclk);
        rst_n          = rst;
        bus0.req_valid = (d == 0) ? rv : 1'b0;
        bus1.req_valid = (d == 1) ? rv : 1'b0;
        bus2.req_valid = (d == 2) ? rv : 1'b0;
`ifdef TRANS_FRAMER_ABORT_EN
        bus0.abort = (d == 0) ? ab : 1'b0;
        bus1.abort = (d == 1) ? ab : 1'b0;
        bus2.abort = (d == 2) ? ab : 1'b0;
`endif
        e.s = s; e.rdy = rdy; e.bsy = bsy; e.cnt = cnt; e.fab = fab; e.tag = tag;
        if (d == 0) q0.push_back(e);
        else if (d == 1) q1.push_back(e);
        else q2.push_back(e);
        if (ab) e.fab = fab;
    endtask

    always @(posedge sysclk) begin : mon0
        exp_t e;
        #1;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            check(e, {bus0.trans, bus0.start_trans, bus0.a, bus0.b, bus0.c, bus0.end_trans},
                  bus0.req_ready, bus0.busy, bus0.frame_cnt);
`ifdef TRANS_FRAMER_ABORT_EN
            check_fab(e, bus0.frame_aborted);
`endif
        end
    end

    always @(posedge sysclk) begin : mon1
        exp_t e;
        #1;
        if (q1.size() > 0) begin
            e = q1.pop_front();
            check(e, {bus1.trans, bus1.start_trans, bus1.a, bus1.b, bus1.c, bus1.end_trans},
                  bus1.req_ready, bus1.busy, bus1.frame_cnt);
        end
    end

    always @(posedge sysclk) begin : mon2
        exp_t e;
        #1;
        if (q2.size() > 0) begin
            e = q2.pop_front();
            check(e, {bus2.trans, bus2.start_trans, bus2.a, bus2.b, bus2.c, bus2.end_trans},
                  bus2.req_ready, bus2.busy, {14'b0, bus2.frame_cnt});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        seq[0] = ST; seq[1] = SS; seq[2] = SA; seq[3] = SB; seq[4] = SC; seq[5] = SE;
        bus0.req_valid = 1'b0; bus1.req_valid = 1'b0; bus2.req_valid = 1'b0;
`ifdef TRANS_FRAMER_ABORT_EN
        bus0.abort = 1'b0; bus1.abort = 1'b0; bus2.abort = 1'b0;
`endif

        // Reset held 3 cycles with req_valid high: nothing starts, not ready.
        for (int i = 0; i < 3; i++) step(0, 1'b0, 1'b1, 1'b0, SN, 1'b0, 1'b0, 16'd0, 1'b0, "rst_hold");
        // Release edge: ready rises, no accept yet (ready was low at that edge).
        step(0, 1'b1, 1'b1, 1'b0, SN, 1'b1, 1'b0, 16'd0, 1'b0, "rst_release");

        // Single frame: accept then six one-hot strobes, count 1 afterwards.
        step(0, 1'b1, 1'b1, 1'b0, ST, 1'b0, 1'b1, 16'd0, 1'b0, "single_T");
        for (int k = 1; k < 6; k++)
            step(0, 1'b1, 1'b0, 1'b0, seq[k], (k == 5), 1'b1, 16'd0, 1'b0, "single_seq");
        step(0, 1'b1, 1'b0, 1'b0, SN, 1'b1, 1'b0, 16'd1, 1'b0, "single_done");

        // req_valid held for 3 frames: 18 contiguous strobe cycles.
        for (int f = 0; f < 3; f++)
            for (int k = 0; k < 6; k++)
                step(0, 1'b1, 1'b1, 1'b0, seq[k], (k == 5), 1'b1, 16'(1 + f), 1'b0, "b2b");
        step(0, 1'b1, 1'b0, 1'b0, SN, 1'b1, 1'b0, 16'd4, 1'b0, "b2b_done");

        // Reset asserted in the S_A cycle: frame abandoned, counter cleared.
        step(0, 1'b1, 1'b1, 1'b0, ST, 1'b0, 1'b1, 16'd4, 1'b0, "midrst_T");
        step(0, 1'b1, 1'b0, 1'b0, SS, 1'b0, 1'b1, 16'd4, 1'b0, "midrst_S");
        step(0, 1'b1, 1'b0, 1'b0, SA, 1'b0, 1'b1, 16'd4, 1'b0, "midrst_A");
        step(0, 1'b0, 1'b0, 1'b0, SN, 1'b0, 1'b0, 16'd0, 1'b0, "midrst_reset");
        step(0, 1'b1, 1'b0, 1'b0, SN, 1'b1, 1'b0, 16'd0, 1'b0, "midrst_release");
        step(0, 1'b1, 1'b0, 1'b0, SN, 1'b1, 1'b0, 16'd0, 1'b0, "midrst_no_end");

        // GAP_CYCLES=2, request held: 2 not-ready gap cycles, then IDLE/ready,
        // so the next trans follows end_trans after the gap plus the accept cycle.
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 6; k++)
                step(1, 1'b1, 1'b1, 1'b0, seq[k], 1'b0, 1'b1, 16'(f), 1'b0, "gap_frame");
            step(1, 1'b1, 1'b1, 1'b0, SN, 1'b0, 1'b1, 16'(f + 1), 1'b0, "gap_1");
            step(1, 1'b1, 1'b1, 1'b0, SN, 1'b0, 1'b1, 16'(f + 1), 1'b0, "gap_2");
            step(1, 1'b1, 1'b1, 1'b0, SN, 1'b1, 1'b0, 16'(f + 1), 1'b0, "gap_idle");
        end
        step(1, 1'b1, 1'b0, 1'b0, SN, 1'b1, 1'b0, 16'd2, 1'b0, "gap_done");

        // CNT_W=2, five back-to-back frames: count runs 1,2,3,0,1.
        for (int f = 0; f < 5; f++)
            for (int k = 0; k < 6; k++)
                step(2, 1'b1, 1'b1, 1'b0, seq[k], (k == 5), 1'b1, 16'(f % 4), 1'b0, "wrap");
        step(2, 1'b1, 1'b0, 1'b0, SN, 1'b1, 1'b0, 16'd1, 1'b0, "wrap_done");

`ifdef TRANS_FRAMER_ABORT_EN
        // Abort in S_B: no c/end_trans, one-cycle frame_aborted, count unchanged.
        step(0, 1'b1, 1'b1, 1'b0, ST, 1'b0, 1'b1, 16'd0, 1'b0, "abort_T");
        step(0, 1'b1, 1'b0, 1'b0, SS, 1'b0, 1'b1, 16'd0, 1'b0, "abort_S");
        step(0, 1'b1, 1'b0, 1'b0, SA, 1'b0, 1'b1, 16'd0, 1'b0, "abort_A");
        step(0, 1'b1, 1'b0, 1'b0, SB, 1'b0, 1'b1, 16'd0, 1'b0, "abort_B");
        step(0, 1'b1, 1'b0, 1'b1, SN, 1'b1, 1'b0, 16'd0, 1'b1, "abort_hit");
        step(0, 1'b1, 1'b0, 1'b0, SN, 1'b1, 1'b0, 16'd0, 1'b0, "abort_pulse_end");
        // Accept wins over abort in IDLE; the frame then completes normally.
        step(0, 1'b1, 1'b1, 1'b1, ST, 1'b0, 1'b1, 16'd0, 1'b0, "abort_idle_T");
        for (int k = 1; k < 6; k++)
            step(0, 1'b1, 1'b0, 1'b0, seq[k], (k == 5), 1'b1, 16'd0, 1'b0, "abort_idle_seq");
        step(0, 1'b1, 1'b0, 1'b0, SN, 1'b1, 1'b0, 16'd1, 1'b0, "abort_idle_done");
`endif

        // Let the monitors consume the last queued expectations.
        repeat (3) @(posedge sysclk);
        #2;
        compared++;
        assert ((q0.size() + q1.size() + q2.size()) == 0) else begin
            mismatched++;
            $error("FAIL drain: observed %0d pending expected 0", q0.size() + q1.size() + q2.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
